// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, hands words to decode under valid/ready.
// Optional misaligned-redirect fault detection is enabled with `define INSTR_FETCH_ALIGN_CHECK_EN.
module instr_fetch #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] instr_address,
    output logic        instr_read,
    input  logic        instr_waitrequest,
    input  logic [31:0] instr_readdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        active,
    output logic        fault
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic [31:0] pending_target_q, pending_target_d;
    logic        pending_q, pending_d;
    logic        fault_q, fault_d;

    logic [31:0] pc_inc;
    logic [31:0] pc_next;
    logic [31:0] target_cap;
    logic        misaligned;

    assign pc_inc = pc_q + 32'd4;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    assign target_cap = redirect_target;
    assign misaligned = (redirect_target[1:0] != 2'b00);
`else
    assign target_cap = redirect_target & ~32'h3;
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        instr_d          = instr_q;
        instr_pc_d       = instr_pc_q;
        pending_d        = pending_q;
        pending_target_d = pending_target_q;
        fault_d          = fault_q;
        pc_next          = pc_inc;

        case (state_q)
            FETCH: begin
                if (!instr_waitrequest) begin
                    instr_d    = instr_readdata;
                    instr_pc_d = pc_q;
                    state_d    = HOLD;
                end
            end
            HOLD: begin
                if (instr_ready) begin
                    // A pending target wins; a redirect in the delay slot is dropped.
                    if (pending_q) begin
                        pc_next   = pending_target_q;
                        pending_d = 1'b0;
                    end else if (redirect) begin
                        pc_next          = pc_inc;
                        pending_d        = 1'b1;
                        pending_target_d = target_cap;
                    end else begin
                        pc_next = pc_inc;
                    end

                    if (!pending_q && redirect && misaligned) begin
                        fault_d   = 1'b1;
                        pending_d = 1'b0;
                        state_d   = HALTED;
                    end else begin
                        pc_d    = pc_next;
                        state_d = (pc_next == HALT_ADDR) ? HALTED : FETCH;
                    end
                end
            end
            default: begin
                state_d = HALTED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= FETCH;
            pc_q             <= RESET_VECTOR;
            instr_q          <= 32'd0;
            instr_pc_q       <= 32'd0;
            pending_q        <= 1'b0;
            pending_target_q <= 32'd0;
            fault_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            instr_q          <= instr_d;
            instr_pc_q       <= instr_pc_d;
            pending_q        <= pending_d;
            pending_target_q <= pending_target_d;
            fault_q          <= fault_d;
        end
    end

    // Control outputs are masked during reset so a stalled read or an offered word is withdrawn at once.
    assign instr_address = pc_q;
    assign instr_read    = (state_q == FETCH) && !reset;
    assign instr_valid   = (state_q == HOLD) && !reset;
    assign active        = (state_q != HALTED) && !reset;
    assign fault         = fault_q && !reset;
    assign instr         = instr_q;
    assign instr_pc      = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch: cycle-by-cycle vectors plus a throughput sequence.
module tb_instr_fetch;

    localparam logic [31:0] A    = 32'hBFC00000;
    localparam logic [31:0] B100 = 32'hBFC00100;
    localparam logic [31:0] B104 = 32'hBFC00104;
    localparam logic [31:0] J    = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] instr_address;
    logic        instr_read;
    logic        instr_waitrequest;
    logic [31:0] instr_readdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        active;
    logic        fault;

    int checks = 0;
    int errors = 0;

    instr_fetch dut (
        .clk               (clk),
        .reset             (reset),
        .redirect          (redirect),
        .redirect_target   (redirect_target),
        .instr_address     (instr_address),
        .instr_read        (instr_read),
        .instr_waitrequest (instr_waitrequest),
        .instr_readdata    (instr_readdata),
        .instr             (instr),
        .instr_pc          (instr_pc),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .active            (active),
        .fault             (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        wr;
        logic        rdy;
        logic        rd;
        logic [31:0] tgt;
        logic [31:0] rdata;
        logic        e_read;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_ipc;
        logic [31:0] e_instr;
        logic        e_act;
        logic        e_flt;
        logic        cd;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] dw(input int i);
        return 32'hA5000000 | 32'(i);
    endfunction

    function automatic vec_t mk(input logic rst, input logic wr, input logic rdy, input logic rd,
                                input logic [31:0] tgt, input logic [31:0] rdata,
                                input logic e_read, input logic [31:0] e_addr, input logic e_valid,
                                input logic [31:0] e_ipc, input logic [31:0] e_instr,
                                input logic e_act, input logic e_flt, input logic cd);
        vec_t v;
        v.rst = rst; v.wr = wr; v.rdy = rdy; v.rd = rd; v.tgt = tgt; v.rdata = rdata;
        v.e_read = e_read; v.e_addr = e_addr; v.e_valid = e_valid; v.e_ipc = e_ipc;
        v.e_instr = e_instr; v.e_act = e_act; v.e_flt = e_flt; v.cd = cd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Inputs are driven just after the rising edge and outputs sampled on the falling edge.
    task automatic apply(input vec_t v, input int idx);
        reset             = v.rst;
        instr_waitrequest = v.wr;
        instr_ready       = v.rdy;
        redirect          = v.rd;
        redirect_target   = v.tgt;
        instr_readdata    = v.rdata;
        @(negedge clk);
        chk($sformatf("v%0d.read", idx),   32'(instr_read),  32'(v.e_read));
        chk($sformatf("v%0d.valid", idx),  32'(instr_valid), 32'(v.e_valid));
        chk($sformatf("v%0d.active", idx), 32'(active),      32'(v.e_act));
        chk($sformatf("v%0d.fault", idx),  32'(fault),       32'(v.e_flt));
        if (v.cd) begin
            chk($sformatf("v%0d.addr", idx),  instr_address, v.e_addr);
            chk($sformatf("v%0d.ipc", idx),   instr_pc,      v.e_ipc);
            chk($sformatf("v%0d.instr", idx), instr,         v.e_instr);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nvalid;
        logic [31:0] exp_pc;

        reset = 1'b1; redirect = 1'b0; redirect_target = '0;
        instr_waitrequest = 1'b1; instr_ready = 1'b0; instr_readdata = '0;

        // rst wr rdy rd tgt rdata | read addr valid ipc instr act flt cd
        tbl.push_back(mk(1,1,0,0,0,J,        0,0,0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1,0,0,J,        0,A,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(0),    1,A,0,0,0,1,0,1));
        tbl.push_back(mk(0,0,1,0,0,J,        0,A,1,A,dw(0),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(1),    1,A+4,0,A,dw(0),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,J,        0,A+4,1,A+4,dw(1),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(2),    1,A+8,0,A+4,dw(1),1,0,1));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,0,0,J,    0,A+8,1,A+8,dw(2),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,J,        0,A+8,1,A+8,dw(2),1,0,1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,1,1,0,0,J,    1,A+12,0,A+8,dw(2),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(3),    1,A+12,0,A+8,dw(2),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,J,        0,A+12,1,A+12,dw(3),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(4),    1,A+16,0,A+12,dw(3),1,0,1));
        tbl.push_back(mk(0,0,1,1,B100,J,     0,A+16,1,A+16,dw(4),1,0,1));
        tbl.push_back(mk(0,0,1,1,A+32'h200,dw(5), 1,A+20,0,A+16,dw(4),1,0,1));
        tbl.push_back(mk(0,0,1,1,A+32'h300,J,     0,A+20,1,A+20,dw(5),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(6),    1,B100,0,A+20,dw(5),1,0,1));
        tbl.push_back(mk(0,0,1,1,A+32,J,     0,B100,1,B100,dw(6),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(7),    1,B104,0,B100,dw(6),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,J,        0,B104,1,B104,dw(7),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(8),    1,A+32,0,B104,dw(7),1,0,1));
        tbl.push_back(mk(0,0,1,1,0,J,        0,A+32,1,A+32,dw(8),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(9),    1,A+36,0,A+32,dw(8),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,J,        0,A+36,1,A+36,dw(9),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(0),    0,0,0,A+36,dw(9),0,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(0),    0,0,0,A+36,dw(9),0,0,1));
        tbl.push_back(mk(1,0,1,0,0,J,        0,0,0,A+36,dw(9),0,0,1));
        tbl.push_back(mk(1,0,1,0,0,J,        0,A,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(0),    1,A,0,0,0,1,0,1));
        tbl.push_back(mk(0,0,1,1,32'hFFFFFFFC,J, 0,A,1,A,dw(0),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(1),    1,A+4,0,A,dw(0),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,J,        0,A+4,1,A+4,dw(1),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(2),    1,32'hFFFFFFFC,0,A+4,dw(1),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,J,        0,32'hFFFFFFFC,1,32'hFFFFFFFC,dw(2),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,J,        0,0,0,32'hFFFFFFFC,dw(2),0,0,1));
        tbl.push_back(mk(1,0,1,0,0,J,        0,0,0,32'hFFFFFFFC,dw(2),0,0,1));
        tbl.push_back(mk(0,1,1,0,0,J,        1,A,0,0,0,1,0,1));
        tbl.push_back(mk(1,1,1,0,0,J,        0,A,0,0,0,0,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(3),    1,A,0,0,0,1,0,1));
        tbl.push_back(mk(1,0,1,0,0,J,        0,A,0,A,dw(3),0,0,1));
        tbl.push_back(mk(0,1,1,0,0,J,        1,A,0,0,0,1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(4),    1,A,0,0,0,1,0,1));
        tbl.push_back(mk(0,0,1,1,A+32'h102,J, 0,A,1,A,dw(4),1,0,1));
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0,0,1,0,0,dw(5), 0,A,0,A,dw(4),0,1,1));
`else
        tbl.push_back(mk(0,0,1,0,0,dw(5),    1,A+4,0,A,dw(4),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,J,        0,A+4,1,A+4,dw(5),1,0,1));
        tbl.push_back(mk(0,0,1,0,0,dw(6),    1,B100,0,A+4,dw(5),1,0,1));
`endif

        @(posedge clk);
        #1;
        foreach (tbl[i]) apply(tbl[i], i);

        // Reset clears fault and restarts at the reset vector.
        reset = 1'b1; redirect = 1'b0; instr_waitrequest = 1'b0; instr_ready = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset.fault", 32'(fault), 32'd0);
        chk("post_reset.addr", instr_address, A);

        // Full-speed streaming: one valid word every second cycle with consecutive PCs.
        nvalid = 0;
        exp_pc = A;
        for (int c = 0; c < 8; c++) begin
            if (instr_valid) begin
                chk($sformatf("stream.ipc%0d", nvalid), instr_pc, exp_pc);
                chk($sformatf("stream.instr%0d", nvalid), instr, ~exp_pc);
                exp_pc = exp_pc + 32'd4;
                nvalid++;
            end
            instr_readdata = ~instr_address;
            @(negedge clk);
        end
        chk("stream.count", 32'(nvalid), 32'd4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
